mmio_test_monitor: RTL and testbench

- Passive, synthesizable-style monitor on the CPU's data-memory store interface, downstream of the cpu in the same wires that feed data_memory.
- Decodes stores to two MMIO addresses: a tohost word, which ends the test with a pass/fail result, and a console byte, which is buffered in a FIFO for the bench to drain.
- Runs a cycle counter with a watchdog timeout, so benches end on a hardware verdict instead of a fixed delay followed by a memory peek.

---
 rtl/control_types.sv | 4 +
 rtl/mmio_test_monitor_pkg.sv | 8 +
 rtl/mmio_test_monitor_byte_fifo.sv | 46 ++++
 rtl/mmio_test_monitor.sv | 62 ++++++
 tb/tb_mmio_test_monitor.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/control_types.sv
// control_types: shared cpu control encodings used by memory-side blocks
package control_types;
  typedef enum logic [1:0] {MEM_BYTE, MEM_HALF, MEM_WORD} mem_op_t;
endpackage

// File: rtl/mmio_test_monitor_pkg.sv
// mmio_test_monitor_pkg: verdict states, default MMIO addresses and pass value
package mmio_test_monitor_pkg;
  typedef control_types::mem_op_t mem_op_t;
  typedef enum logic [1:0] {RUN, PASSED, FAILED, TIMED_OUT} mon_state_t;
  localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_0200;
  localparam logic [31:0] DEFAULT_CONSOLE_ADDR = 32'h0000_0204;
  localparam logic [31:0] PASS_VALUE = 32'd1;
endpackage

// File: rtl/mmio_test_monitor_byte_fifo.sv
// byte_fifo: show-ahead byte FIFO with sticky overflow on dropped pushes
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       valid,
  output logic       full,
  output logic       overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [AW:0] count;
  logic do_push, do_pop;
  logic [7:0] head_next;
  assign valid = count != '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop & valid;
  assign do_push = push & (~full | do_pop);
  assign rd_nxt = rd_ptr + 1'b1;
  // dout is a register so it keeps the last byte once the FIFO drains
  assign head_next = (!valid || (do_pop && count == (AW+1)'(1))) ? (do_push ? din : dout)
                   : (do_pop ? mem[rd_nxt] : dout);
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      dout <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_nxt;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      dout <= head_next;
      overflow <= overflow | (push & ~do_push);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/mmio_test_monitor.sv
// mmio_test_monitor: snoops cpu stores for tohost verdicts, console bytes and a watchdog
module mmio_test_monitor import mmio_test_monitor_pkg::*; #(
  parameter logic [31:0] TOHOST_ADDR = DEFAULT_TOHOST_ADDR,
  parameter logic [31:0] CONSOLE_ADDR = DEFAULT_CONSOLE_ADDR,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_wr_en,
  input  mem_op_t     mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data_in,
  input  logic        console_rd_en,
  output logic [7:0]  console_data,
  output logic        console_valid,
  output logic        console_overflow,
  output logic [31:0] cycle_count,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [30:0] fail_code
);
  mon_state_t state, state_next;
  logic tohost_wr, console_wr, terminal, fifo_full, unused;
  assign tohost_wr = mem_wr_en && mem_addr == TOHOST_ADDR;
  assign console_wr = mem_wr_en && mem_addr == CONSOLE_ADDR;
  assign terminal = state == RUN && tohost_wr && mem_data_in[0];
  assign unused = ^{mem_op, fifo_full};
  always_ff @(posedge clk)
    state <= reset ? RUN : state_next;
  // a terminal tohost store outranks the watchdog in the same cycle
  always_comb
    state_next = state != RUN ? state
               : terminal ? (mem_data_in == PASS_VALUE ? PASSED : FAILED)
               : cycle_count == 32'(TIMEOUT_CYCLES - 1) ? TIMED_OUT : RUN;
  always_comb begin
    done = state != RUN;
    pass = state == PASSED;
    timeout = state == TIMED_OUT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
      fail_code <= '0;
    end else begin
      if (state == RUN && state_next == RUN && cycle_count != '1) cycle_count <= cycle_count + 1'b1;
      if (state == RUN && state_next == FAILED) fail_code <= mem_data_in[31:1];
    end
  end
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push(console_wr),
    .din(mem_data_in[7:0]),
    .pop(console_rd_en),
    .dout(console_data),
    .valid(console_valid),
    .full(fifo_full),
    .overflow(console_overflow)
  );
endmodule

// File: tb/tb_mmio_test_monitor.sv
// tb_mmio_test_monitor: directed plan plus random stores checked against a queue-based model
module tb_mmio_test_monitor;
  import mmio_test_monitor_pkg::*;
  localparam int T = 50;
  localparam int D = 4;
  localparam logic [31:0] TH = 32'h200;
  localparam logic [31:0] CO = 32'h204;
  logic clk = 1'b0, reset = 1'b1, mem_wr_en = 1'b0, console_rd_en = 1'b0;
  mem_op_t mem_op = mem_op_t'(2'd2);
  logic [31:0] mem_addr = '0, mem_data_in = '0;
  logic [7:0] console_data;
  logic console_valid, console_overflow, done, pass, timeout;
  logic [31:0] cycle_count;
  logic [30:0] fail_code;
  int checks = 0, errors = 0;
  logic [7:0] q[$];
  logic [7:0] m_data = '0;
  bit m_done, m_pass, m_to, m_ovf;
  logic [30:0] m_fc;
  logic [31:0] m_cnt;
  always #5 clk = ~clk;
  mmio_test_monitor #(.TIMEOUT_CYCLES(T), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .mem_wr_en(mem_wr_en), .mem_op(mem_op), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .console_rd_en(console_rd_en), .console_data(console_data),
    .console_valid(console_valid), .console_overflow(console_overflow), .cycle_count(cycle_count),
    .done(done), .pass(pass), .timeout(timeout), .fail_code(fail_code)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model(bit rst, bit wr, logic [31:0] a, logic [31:0] d, bit rd);
    bit pop, push;
    int sz;
    if (rst) begin
      q.delete(); m_data = '0; m_done = 0; m_pass = 0; m_to = 0; m_ovf = 0; m_fc = '0; m_cnt = '0;
      return;
    end
    if (!m_done && wr && a == TH && d[0]) begin
      m_done = 1;
      if (d == 32'd1) m_pass = 1; else m_fc = d[31:1];
    end else if (!m_done && m_cnt == T - 1) begin
      m_done = 1; m_to = 1;
    end else if (!m_done && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    sz = q.size();
    pop = rd && sz > 0;
    push = wr && a == CO;
    if (pop) void'(q.pop_front());
    if (push) begin
      if (sz < D || pop) q.push_back(d[7:0]); else m_ovf = 1;
    end
    if (q.size() > 0) m_data = q[0];
  endtask
  task automatic step(bit rst, bit wr, logic [31:0] a, logic [31:0] d, bit rd);
    reset = rst; mem_wr_en = wr; mem_addr = a; mem_data_in = d; console_rd_en = rd;
    mem_op = mem_op_t'($urandom_range(0, 2));
    @(posedge clk);
    model(rst, wr, a, d, rd);
    #1;
    check("done", done, m_done);
    check("pass", pass, m_pass);
    check("timeout", timeout, m_to);
    check("fail_code", fail_code, m_fc);
    check("cycle_count", cycle_count, m_cnt);
    check("valid", console_valid, q.size() > 0);
    check("data", console_data, m_data);
    check("overflow", console_overflow, m_ovf);
    reset = 0; mem_wr_en = 0; console_rd_en = 0;
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0);
  endtask
  task automatic store(logic [31:0] a, logic [31:0] d);
    step(0, 1, a, d, 0);
  endtask
  task automatic pop1();
    step(0, 0, '0, '0, 1);
  endtask
  initial begin
    logic [31:0] a, d;
    step(1, 0, '0, '0, 0);
    check("rst_done", done, 0);
    check("rst_cnt", cycle_count, 0);
    check("rst_data", console_data, 0);
    idle(20);
    store(TH, 32'h1);
    check("pass_done", done, 1);
    check("pass_pass", pass, 1);
    check("pass_cnt", cycle_count, 20);
    store(TH, 32'h7);
    check("pass_sticky", pass, 1);
    check("pass_fc", fail_code, 0);
    step(1, 0, '0, '0, 0);
    store(TH, 32'h4);
    check("even_ignored", done, 0);
    store(TH, 32'h7);
    check("fail_done", done, 1);
    check("fail_pass", pass, 0);
    check("fail_code3", fail_code, 3);
    step(1, 0, '0, '0, 0);
    idle(50);
    check("to_flag", timeout, 1);
    check("to_cnt", cycle_count, 49);
    step(1, 0, '0, '0, 0);
    idle(49);
    store(TH, 32'h1);
    check("race_pass", pass, 1);
    check("race_to", timeout, 0);
    step(1, 0, '0, '0, 0);
    store(CO, 32'h48);
    store(CO, 32'h69);
    check("hi_valid", console_valid, 1);
    check("hi_h", console_data, 8'h48);
    pop1();
    check("hi_i", console_data, 8'h69);
    pop1();
    check("hi_empty", console_valid, 0);
    store(CO, 32'h1234_5641);
    check("low_byte", console_data, 8'h41);
    pop1();
    step(1, 0, '0, '0, 0);
    for (int i = 0; i < 5; i++) store(CO, 32'h10 + i);
    check("ovf_set", console_overflow, 1);
    for (int i = 0; i < 4; i++) begin
      check("ovf_order", console_data, 32'h10 + i);
      pop1();
    end
    check("ovf_drained", console_valid, 0);
    step(1, 0, '0, '0, 0);
    for (int i = 0; i < 4; i++) store(CO, 32'h20 + i);
    step(0, 1, CO, 32'h2F, 1);
    check("full_pp_ovf", console_overflow, 0);
    check("full_pp_head", console_data, 8'h21);
    step(1, 0, '0, '0, 0);
    step(0, 1, CO, 32'h55, 1);
    check("empty_pp_valid", console_valid, 1);
    check("empty_pp_data", console_data, 8'h55);
    step(1, 0, '0, '0, 0);
    store(TH, 32'h1);
    for (int i = 0; i < 3; i++) store(CO, 32'h30 + i);
    step(1, 0, '0, '0, 0);
    check("rr_done", done, 0);
    check("rr_valid", console_valid, 0);
    check("rr_cnt", cycle_count, 0);
    store(TH, 32'hB);
    check("rr_fc", fail_code, 5);
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 5))
        0: a = TH;
        1, 2: a = CO;
        3: a = TH + 32'($urandom_range(1, 3));
        4: a = CO + 32'($urandom_range(1, 7));
        default: a = $urandom;
      endcase
      d = $urandom;
      if (a == TH && $urandom_range(0, 7) != 0) d[0] = 1'b0;
      step($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0, a, d, $urandom_range(0, 2) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
